// File: rtl/fp_pkg.sv
// Shared definitions for the binary32 floating-point datapath.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    // Significand with hidden bit, and its aligned form carrying guard/round/sticky.
    localparam int SIG_W = FRAC_W + 1;
    localparam int EXT_W = SIG_W + 3;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } fp_unpacked_t;

    // Zero and subnormal inputs both become a signed zero (flush-to-zero).
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] v);
        fp_unpacked_t u;
        u.sign = v[31];
        u.exp  = v[30:23];
        if (v[30:23] == '0) begin
            u.sig = '0;
        end else begin
            u.sig = {1'b1, v[22:0]};
        end
        return u;
    endfunction

endpackage

// File: rtl/fpadd_single_lzc26.sv
// Leading-zero counter for the 27-bit pre-normalization sum (significand + G/R/S).
// An all-zero input reports 27; the caller never shifts that case.
module lzc26 (
    input  logic [26:0] vec_i,
    output logic [4:0]  count_o
);

    // Scan from LSB to MSB so the highest set bit determines the final count.
    always_comb begin
        count_o = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (vec_i[i]) begin
                count_o = 5'(26 - i);
            end
        end
    end

endmodule

// File: rtl/fpadd_single.sv
// Binary32 adder: operands registered, single-cycle add core, registered result.
// Round-to-nearest-even, flush-to-zero on input and output, no exception flags.
module fpadd_single
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] reg_A,
    input  logic [31:0] reg_B,
    output logic [31:0] out
);

    logic [31:0] a_q, b_q, out_q, out_d;

    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic swap, eff_sub, cancel;

    fp_unpacked_t ua, ub, ux, uy;

    logic [EXP_W-1:0]    exp_diff;
    logic [EXT_W-1:0]    x_al, y_ext, y_al, lost_mask;
    logic [EXT_W:0]      sum;
    logic [4:0]          lz;
    logic [EXT_W-1:0]    norm;
    logic signed [EXP_W+1:0] exp_x_s, exp_n, exp_r;
    logic                round_up;
    logic [SIG_W:0]      mant_r;
    logic [FRAC_W-1:0]   frac_r;

    assign a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != '0);
    assign b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != '0);
    assign a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == '0);
    assign b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == '0);
    assign a_zero = (a_q[30:23] == '0);
    assign b_zero = (b_q[30:23] == '0);

    assign ua = fp_unpack(a_q);
    assign ub = fp_unpack(b_q);

    // Magnitude order on {exp, frac}; ties keep A as X.
    assign swap    = (b_q[30:0] > a_q[30:0]);
    assign eff_sub = a_q[31] ^ b_q[31];
    assign cancel  = eff_sub && !a_zero && !b_zero && (a_q[30:0] == b_q[30:0]);

    // Operand registers and result register; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            out_q <= '0;
        end else begin
            a_q   <= reg_A;
            b_q   <= reg_B;
            out_q <= out_d;
        end
    end

    assign out = out_q;

    // Swap, align Y into X's exponent keeping G/R/S, then add or subtract magnitudes.
    always_comb begin
        ux        = swap ? ub : ua;
        uy        = swap ? ua : ub;
        exp_diff  = ux.exp - uy.exp;
        x_al      = {ux.sig, 3'b000};
        y_ext     = {uy.sig, 3'b000};
        lost_mask = '0;
        y_al      = '0;
        if (exp_diff >= 8'(EXT_W)) begin
            y_al = {{(EXT_W-1){1'b0}}, |uy.sig};
        end else begin
            lost_mask = (EXT_W'(1) << exp_diff) - EXT_W'(1);
            y_al      = (y_ext >> exp_diff)
                      | {{(EXT_W-1){1'b0}}, |(y_ext & lost_mask)};
        end
        if (eff_sub) begin
            sum = {1'b0, x_al} - {1'b0, y_al};
        end else begin
            sum = {1'b0, x_al} + {1'b0, y_al};
        end
    end

    lzc26 u_lzc (
        .vec_i   (sum[EXT_W-1:0]),
        .count_o (lz)
    );

    assign exp_x_s = $signed({2'b00, ux.exp});

    // Normalize (carry right-shift or leading-zero left-shift), then round to nearest even.
    always_comb begin
        if (sum[EXT_W]) begin
            norm  = {sum[EXT_W:2], sum[1] | sum[0]};
            exp_n = exp_x_s + 10'sd1;
        end else begin
            norm  = sum[EXT_W-1:0] << lz;
            exp_n = exp_x_s - $signed({5'b00000, lz});
        end
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r   = {1'b0, norm[EXT_W-1:3]} + {{SIG_W{1'b0}}, round_up};
        if (mant_r[SIG_W]) begin
            exp_r  = exp_n + 10'sd1;
            frac_r = mant_r[SIG_W-1:1];
        end else begin
            exp_r  = exp_n;
            frac_r = mant_r[FRAC_W-1:0];
        end
    end

    // Special-case priority mux in front of the result register.
    always_comb begin
        out_d = {ux.sign, exp_r[EXP_W-1:0], frac_r};
        if (a_nan || b_nan) begin
            out_d = QNAN;
        end else if (a_inf && b_inf && (a_q[31] != b_q[31])) begin
            out_d = QNAN;
        end else if (a_inf) begin
            out_d = {a_q[31], POS_INF[30:0]};
        end else if (b_inf) begin
            out_d = {b_q[31], POS_INF[30:0]};
        end else if (cancel) begin
            out_d = '0;
        end else if (a_zero && b_zero) begin
            out_d = {a_q[31] & b_q[31], 31'b0};
        end else if (a_zero) begin
            out_d = b_q;
        end else if (b_zero) begin
            out_d = a_q;
        end else if (exp_r >= 10'sd255) begin
            out_d = {ux.sign, POS_INF[30:0]};
        end else if (exp_n <= 10'sd0) begin
            out_d = {ux.sign, 31'b0};
        end
    end

endmodule

// File: tb/tb_fpadd_single.sv
// Scoreboarded bench for fpadd_single: directed vectors, reset/latency, random traffic.
module tb_fpadd_single;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] reg_A, reg_B, out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic drain_timeout = 1'b0;
    logic drain_seen    = 1'b0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expv;
        int          due;
        int          id;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    fpadd_single dut (
        .clk   (clk),
        .reset (reset),
        .reg_A (reg_A),
        .reg_B (reg_B),
        .out   (out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model (binary64 arithmetic) ----------------
    function automatic real f32_to_real(input logic [31:0] v);
        logic [63:0] d;
        if (v[30:23] == 8'h00) begin
            d = {v[31], 63'b0};
        end else begin
            d = {v[31], 11'({3'b000, v[30:23]} + 11'd896), v[22:0], 29'b0};
        end
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] d;
        int          fe;
        logic [24:0] m;
        logic [28:0] rest;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'b0};
        fe = int'(d[62:52]) - 896;
        if (fe <= 0) return {d[63], 31'b0};
        m    = {2'b01, d[51:29]};
        rest = d[28:0];
        if (rest > 29'h1000_0000 || (rest == 29'h1000_0000 && m[0])) m = m + 25'd1;
        if (m[24]) begin
            fe = fe + 1;
            m  = m >> 1;
        end
        if (fe >= 255) return {d[63], 8'hFF, 23'b0};
        return {d[63], 8'(fe), m[22:0]};
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic a_nan, b_nan, a_inf, b_inf, a_z, b_z;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        a_z   = (a[30:23] == 8'h00);
        b_z   = (b[30:23] == 8'h00);
        if (a_nan || b_nan) return 32'h7FC0_0000;
        if (a_inf && b_inf && (a[31] != b[31])) return 32'h7FC0_0000;
        if (a_inf) return {a[31], 31'h7F80_0000};
        if (b_inf) return {b[31], 31'h7F80_0000};
        if (a_z && b_z) return {a[31] & b[31], 31'b0};
        if (a_z) return b;
        if (b_z) return a;
        return real_to_f32(f32_to_real(a) + f32_to_real(b));
    endfunction

    // ---------------- monitor ----------------
    // Pops every expectation whose due cycle has arrived and compares it to out.
    always @(negedge clk) begin
        if (drain_timeout && !drain_seen) begin
            drain_seen = 1'b1;
            checks     = checks + 1;
            failures   = failures + 1;
            $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
        end
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e  = sb_q.pop_front();
            checks = checks + 1;
            if (mon_e.due != cyc) begin
                failures = failures + 1;
                $display("FAIL stale id=%0d due=%0d now=%0d", mon_e.id, mon_e.due, cyc);
            end else if (out !== mon_e.expv) begin
                failures = failures + 1;
                $display("FAIL sum id=%0d a=%08h b=%08h got=%08h want=%08h",
                         mon_e.id, mon_e.a, mon_e.b, out, mon_e.expv);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want, input int id);
        @(negedge clk);
        reg_A = a;
        reg_B = b;
        sb_q.push_back('{a, b, want, cyc + 2, id});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            drain_timeout = 1'b1;
            @(negedge clk);
            @(negedge clk);
            sb_q.delete();
        end
    endtask

    function automatic logic [31:0] rand_op(input logic [31:0] other);
        logic [31:0] specials [10];
        int          e;
        specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                     32'h7FC0_0000, 32'h7F80_0001, 32'h0000_0001, 32'h7F7F_FFFF,
                     32'h0080_0000, 32'h8080_0000};
        case ($urandom_range(0, 9))
            0: return specials[$urandom_range(0, 9)];
            1: return other ^ 32'h8000_0000;
            2: return {1'($urandom_range(0, 1)), other[30:23], 23'($urandom)};
            3: begin
                e = int'(other[30:23]) + int'($urandom_range(0, 60)) - 30;
                if (e < 1) e = 1;
                if (e > 254) e = 254;
                return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
            end
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] dir_a [21];
    logic [31:0] dir_b [21];
    logic [31:0] dir_e [21];

    initial begin
        dir_a = '{32'h3F80_0000, 32'h3FC0_0000, 32'h3F80_0000, 32'h4040_0000, 32'h3F80_0000,
                  32'h3F80_0001, 32'h7F7F_FFFF, 32'h7F80_0000, 32'h7FC0_0000, 32'h0000_0000,
                  32'h4B80_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'hFF80_0000,
                  32'h3F80_0000, 32'hBF80_0000, 32'h0080_0000, 32'h7F00_0000, 32'h3F80_0000,
                  32'h4B7F_FFFF};
        dir_b = '{32'h3F80_0000, 32'h4010_0000, 32'hBF80_0000, 32'hBF80_0000, 32'h3380_0000,
                  32'h3380_0000, 32'h7F7F_FFFF, 32'hFF80_0000, 32'h3F80_0000, 32'hC000_0000,
                  32'h3F80_0000, 32'h8000_0000, 32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000,
                  32'hFF80_0000, 32'h3F80_0000, 32'h8080_0001, 32'h7F00_0000, 32'h0000_0000,
                  32'h3F00_0000};
        dir_e = '{32'h4000_0000, 32'h4070_0000, 32'h0000_0000, 32'h4000_0000, 32'h3F80_0000,
                  32'h3F80_0002, 32'h7F80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'hC000_0000,
                  32'h4B80_0000, 32'h8000_0000, 32'h0000_0000, 32'h3F80_0000, 32'hFF80_0000,
                  32'hFF80_0000, 32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'h3F80_0000,
                  32'h4B80_0000};
    end

    initial begin
        logic [31:0] ra, rb;
        int          c;
        reset = 1'b1;
        reg_A = 32'h3F80_0000;
        reg_B = 32'h3F80_0000;
        sb_q.push_back('{reg_A, reg_B, 32'h0, 1, 1000});
        sb_q.push_back('{reg_A, reg_B, 32'h0, 2, 1001});
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) drive(dir_a[i], dir_b[i], dir_e[i], i);
        wait_drain();

        // Reset with an operation pending: out stays 0, result appears 2 edges after release.
        @(negedge clk);
        c     = cyc;
        reg_A = 32'h3F80_0000;
        reg_B = 32'h3F80_0000;
        reset = 1'b1;
        sb_q.push_back('{reg_A, reg_B, 32'h0, c + 1, 2000});
        sb_q.push_back('{reg_A, reg_B, 32'h0, c + 2, 2001});
        sb_q.push_back('{reg_A, reg_B, 32'h4000_0000, c + 3, 2002});
        @(negedge clk);
        reset = 1'b0;
        wait_drain();

        // Back-to-back random traffic, one new pair every cycle.
        ra = 32'h3F80_0000;
        for (int i = 0; i < 3000; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? rand_op(ra) : $urandom;
            rb = rand_op(ra);
            if ($urandom_range(0, 1) == 1) drive(ra, rb, ref_add(ra, rb), 3000 + i);
            else                           drive(rb, ra, ref_add(rb, ra), 3000 + i);
        end
        wait_drain();

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
